kbd_joypad: RTL
===============

KBD_JOYPAD -- requirements
Module: kbd_joypad

Interface
REQ-001 Parameter TURBO_DIV, default 416667, clock_25 cycles per turbo phase (60 Hz phase, 30 Hz press rate).
REQ-002 clock_25  in  1  system clock; all logic on posedge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 kbd  in  8  PS/2 set-2 byte from the keyboard receiver, valid when hit=1.
REQ-005 hit  in  1  one-cycle strobe: kbd holds a new byte.
REQ-006 clear  in  1  one-cycle strobe: release all buttons (focus loss/replug).
REQ-007 joy1  out  8  player 1 pad {RIGHT,LEFT,DOWN,UP,START,SELECT,A,B}, bit0=B, 1=pressed.
REQ-008 joy2  out  8  player 2 pad, same bit order.

Function
REQ-009 Parser FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), SKIP (E1 sequence).
REQ-010 IDLE: E0->EXT, F0->BRK, E1->SKIP with skip counter=7, other byte -> make of non-extended code, stay IDLE.
REQ-011 EXT: F0->EXT_BRK, else make of extended code -> IDLE; BRK: break of non-extended code -> IDLE; EXT_BRK: break of extended code -> IDLE.
REQ-012 SKIP: each hit decrements counter; at 0 -> IDLE; the 8-byte Pause sequence never changes joy1/joy2.
REQ-013 Bytes AA, FA, FE, EE, 00, FF in IDLE are ignored without state change.
REQ-014 Player 1 map: non-ext 22=B, 1A=A, 21=SELECT, 2A=START; ext 75/72/6B/74=UP/DOWN/LEFT/RIGHT; non-ext 75/72/6B/74 (numpad) also player 1 directions.
REQ-015 Player 2 map (non-ext): 31=B, 3A=A, 41=SELECT, 49=START, 43=UP, 42=DOWN, 3B=LEFT, 4B=RIGHT.
REQ-016 Unmapped codes: no output change; FSM transitions still apply.
REQ-017 Make sets, break clears the mapped held bit; repeated make (typematic) is idempotent.
REQ-018 joy outputs registered; update visible the cycle after the hit carrying the final byte of a sequence (1-cycle latency).
REQ-019 Opposing directions: when UP and DOWN (or LEFT and RIGHT) are both held, the most recently pressed wins, the other bit is masked at the output until released.
REQ-020 clear: all held bits and turbo latches zeroed, FSM -> IDLE, same cycle priority over hit.

Reset
REQ-021 On reset_n=0 at posedge: joy1=joy2=0, FSM=IDLE, skip counter=0, turbo divider=0, turbo phase=0.
REQ-022 Reset mid-sequence (e.g. after E0) discards the prefix; the next byte is parsed from IDLE.

Configuration
REQ-023 Macro KBD_JOYPAD_TURBO_EN defined: non-ext 1C=turbo B, 1B=turbo A for player 1; while held, bit ORs with turbo phase, toggling every TURBO_DIV cycles; divider free-runs and wraps to 0 after TURBO_DIV-1.
REQ-024 Macro undefined: 1C/1B unmapped, no divider logic; output = held bits only.

Structure
REQ-025 Shared package holds FSM state encoding, joypad bit indices, scancode constants (prefixes, mapped codes).
REQ-026 One sub-module kbd_joypad_decode: combinational scancode+ext flag -> {player, bit index, valid}.
REQ-027 FSM, held registers, direction priority, turbo in top module; estimated 150-300 lines RTL.

Verification
REQ-028 Bytes 22; F0 22 -> joy1=01 one cycle after first hit, 00 one cycle after second 22.
REQ-029 E0 74; E0 F0 74 -> joy1=80, then 00; interleaved 43 hit -> joy2=10, joy1 unaffected.
REQ-030 E1 14 77 E1 F0 14 F0 77 then 22 -> joy1/joy2 stay 00 through sequence, then joy1=01.
REQ-031 Hold ext 6B, then ext 74 -> joy1=80 (LEFT masked); break 74 -> joy1=40.
REQ-032 Hold 22, reset_n low one cycle -> joy1=00; E0 then reset then 74 -> joy1=80 (numpad path).
REQ-033 TURBO_EN, TURBO_DIV=4: hold 1C -> joy1[0] toggles every 4 cycles; clear strobe -> joy1=00 next cycle.

Source files
------------

// File: rtl/kbd_joypad_pkg.sv
// Shared definitions for the PS/2 keyboard to joypad bridge: parser states,
// joypad bit positions, scancode constants and small helpers.
package kbd_joypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } state_t;

    // Joypad bit positions, bit0 = B
    localparam logic [2:0] BIT_B      = 3'd0;
    localparam logic [2:0] BIT_A      = 3'd1;
    localparam logic [2:0] BIT_SELECT = 3'd2;
    localparam logic [2:0] BIT_START  = 3'd3;
    localparam logic [2:0] BIT_UP     = 3'd4;
    localparam logic [2:0] BIT_DOWN   = 3'd5;
    localparam logic [2:0] BIT_LEFT   = 3'd6;
    localparam logic [2:0] BIT_RIGHT  = 3'd7;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;
    localparam logic [2:0] SKIP_LEN = 3'd7;

    localparam logic [7:0] SC_P1_B      = 8'h22;
    localparam logic [7:0] SC_P1_A      = 8'h1A;
    localparam logic [7:0] SC_P1_SELECT = 8'h21;
    localparam logic [7:0] SC_P1_START  = 8'h2A;
    localparam logic [7:0] SC_P1_TB     = 8'h1C;
    localparam logic [7:0] SC_P1_TA     = 8'h1B;
    localparam logic [7:0] SC_UP        = 8'h75;
    localparam logic [7:0] SC_DOWN      = 8'h72;
    localparam logic [7:0] SC_LEFT      = 8'h6B;
    localparam logic [7:0] SC_RIGHT     = 8'h74;

    localparam logic [7:0] SC_P2_B      = 8'h31;
    localparam logic [7:0] SC_P2_A      = 8'h3A;
    localparam logic [7:0] SC_P2_SELECT = 8'h41;
    localparam logic [7:0] SC_P2_START  = 8'h49;
    localparam logic [7:0] SC_P2_UP     = 8'h43;
    localparam logic [7:0] SC_P2_DOWN   = 8'h42;
    localparam logic [7:0] SC_P2_LEFT   = 8'h3B;
    localparam logic [7:0] SC_P2_RIGHT  = 8'h4B;

    typedef struct packed {
        logic       valid;
        logic       player;
        logic       turbo;
        logic [2:0] idx;
    } key_map_t;

    function automatic key_map_t mk_map(input logic player, input logic turbo,
                                        input logic [2:0] idx);
        key_map_t m;
        m.valid  = 1'b1;
        m.player = player;
        m.turbo  = turbo;
        m.idx    = idx;
        return m;
    endfunction

    // Keyboard status/ack bytes that never start a scancode
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
               (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    // When both opposing directions are held, only the most recent press survives
    function automatic logic [7:0] resolve_dirs(input logic [7:0] h,
                                                input logic last_up,
                                                input logic last_left);
        logic [7:0] r;
        r = h;
        if (h[BIT_UP] && h[BIT_DOWN]) begin
            if (last_up) r[BIT_DOWN] = 1'b0;
            else         r[BIT_UP]   = 1'b0;
        end
        if (h[BIT_LEFT] && h[BIT_RIGHT]) begin
            if (last_left) r[BIT_RIGHT] = 1'b0;
            else           r[BIT_LEFT]  = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/kbd_joypad_decode.sv
// Combinational scancode lookup: code + extended flag -> {player, bit, valid}.
// Turbo keys (1C/1B) exist only when KBD_JOYPAD_TURBO_EN is defined.
module kbd_joypad_decode
    import kbd_joypad_pkg::*;
(
    input  logic [7:0] i_code,
    input  logic       i_ext,
    output key_map_t   o_map
);

    always_comb begin
        o_map = '0;
        if (i_ext) begin
            case (i_code)
                SC_UP:    o_map = mk_map(1'b0, 1'b0, BIT_UP);
                SC_DOWN:  o_map = mk_map(1'b0, 1'b0, BIT_DOWN);
                SC_LEFT:  o_map = mk_map(1'b0, 1'b0, BIT_LEFT);
                SC_RIGHT: o_map = mk_map(1'b0, 1'b0, BIT_RIGHT);
                default:  o_map = '0;
            endcase
        end else begin
            case (i_code)
                SC_P1_B:      o_map = mk_map(1'b0, 1'b0, BIT_B);
                SC_P1_A:      o_map = mk_map(1'b0, 1'b0, BIT_A);
                SC_P1_SELECT: o_map = mk_map(1'b0, 1'b0, BIT_SELECT);
                SC_P1_START:  o_map = mk_map(1'b0, 1'b0, BIT_START);
                SC_UP:        o_map = mk_map(1'b0, 1'b0, BIT_UP);
                SC_DOWN:      o_map = mk_map(1'b0, 1'b0, BIT_DOWN);
                SC_LEFT:      o_map = mk_map(1'b0, 1'b0, BIT_LEFT);
                SC_RIGHT:     o_map = mk_map(1'b0, 1'b0, BIT_RIGHT);
`ifdef KBD_JOYPAD_TURBO_EN
                SC_P1_TB:     o_map = mk_map(1'b0, 1'b1, BIT_B);
                SC_P1_TA:     o_map = mk_map(1'b0, 1'b1, BIT_A);
`endif
                SC_P2_B:      o_map = mk_map(1'b1, 1'b0, BIT_B);
                SC_P2_A:      o_map = mk_map(1'b1, 1'b0, BIT_A);
                SC_P2_SELECT: o_map = mk_map(1'b1, 1'b0, BIT_SELECT);
                SC_P2_START:  o_map = mk_map(1'b1, 1'b0, BIT_START);
                SC_P2_UP:     o_map = mk_map(1'b1, 1'b0, BIT_UP);
                SC_P2_DOWN:   o_map = mk_map(1'b1, 1'b0, BIT_DOWN);
                SC_P2_LEFT:   o_map = mk_map(1'b1, 1'b0, BIT_LEFT);
                SC_P2_RIGHT:  o_map = mk_map(1'b1, 1'b0, BIT_RIGHT);
                default:      o_map = '0;
            endcase
        end
    end

endmodule

// File: rtl/kbd_joypad.sv
// PS/2 set-2 keyboard to two-player joypad bridge: prefix parser, held-key
// registers, opposing-direction priority. Turbo buttons under KBD_JOYPAD_TURBO_EN.
module kbd_joypad
    import kbd_joypad_pkg::*;
#(
    parameter int TURBO_DIV = 416667
) (
    input  logic       clock_25,
    input  logic       reset_n,
    input  logic [7:0] kbd,
    input  logic       hit,
    input  logic       clear,
    output logic [7:0] joy1,
    output logic [7:0] joy2
);

    state_t      r_state, w_state_next;
    logic [2:0]  r_skip, w_skip_next;
    logic        w_act, w_make, w_ext;
    key_map_t    w_map;
    logic [15:0] r_held, w_held_next;
    logic [1:0]  r_last_up, w_last_up_next;
    logic [1:0]  r_last_left, w_last_left_next;
    logic [7:0]  w_turbo_or;
    logic [7:0]  r_joy1, r_joy2;

    always_ff @(posedge clock_25) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_skip  <= '0;
        end else begin
            r_state <= w_state_next;
            r_skip  <= w_skip_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_skip_next  = r_skip;
        w_act        = 1'b0;
        w_make       = 1'b0;
        w_ext        = 1'b0;
        if (clear) begin
            w_state_next = ST_IDLE;
            w_skip_next  = '0;
        end else if (hit) begin
            case (r_state)
                ST_IDLE: begin
                    if (kbd == SC_EXT) begin
                        w_state_next = ST_EXT;
                    end else if (kbd == SC_BRK) begin
                        w_state_next = ST_BRK;
                    end else if (kbd == SC_PAUSE) begin
                        w_state_next = ST_SKIP;
                        w_skip_next  = SKIP_LEN;
                    end else if (!is_ignored(kbd)) begin
                        w_act  = 1'b1;
                        w_make = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (kbd == SC_BRK) begin
                        w_state_next = ST_EXT_BRK;
                    end else begin
                        w_act        = 1'b1;
                        w_make       = 1'b1;
                        w_ext        = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    w_act        = 1'b1;
                    w_state_next = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    w_act        = 1'b1;
                    w_ext        = 1'b1;
                    w_state_next = ST_IDLE;
                end
                ST_SKIP: begin
                    // Pause sends 7 more bytes after E1; swallow them all
                    if (r_skip <= 3'd1) begin
                        w_skip_next  = '0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_skip_next  = r_skip - 3'd1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    kbd_joypad_decode u_decode (
        .i_code (kbd),
        .i_ext  (w_ext),
        .o_map  (w_map)
    );

    always_comb begin
        w_held_next      = r_held;
        w_last_up_next   = r_last_up;
        w_last_left_next = r_last_left;
        if (clear) begin
            w_held_next = '0;
        end else if (w_act && w_map.valid && !w_map.turbo) begin
            w_held_next[{w_map.player, w_map.idx}] = w_make;
            if (w_make) begin
                case (w_map.idx)
                    BIT_UP:    w_last_up_next[w_map.player]   = 1'b1;
                    BIT_DOWN:  w_last_up_next[w_map.player]   = 1'b0;
                    BIT_LEFT:  w_last_left_next[w_map.player] = 1'b1;
                    BIT_RIGHT: w_last_left_next[w_map.player] = 1'b0;
                    default: ;
                endcase
            end
        end
    end

`ifdef KBD_JOYPAD_TURBO_EN
    localparam int DIV_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic             r_phase, w_phase_next;
    logic [1:0]       r_turbo, w_turbo_next;

    always_comb begin
        w_phase_next = (r_div == DIV_W'(TURBO_DIV - 1)) ? ~r_phase : r_phase;
        w_turbo_next = r_turbo;
        if (clear) begin
            w_turbo_next = '0;
        end else if (w_act && w_map.valid && w_map.turbo) begin
            w_turbo_next[w_map.idx[0]] = w_make;
        end
        w_turbo_or = {6'b0, w_turbo_next & {2{w_phase_next}}};
    end

    always_ff @(posedge clock_25) begin
        if (!reset_n) begin
            r_div   <= '0;
            r_phase <= 1'b0;
            r_turbo <= '0;
        end else begin
            r_div   <= (r_div == DIV_W'(TURBO_DIV - 1)) ? '0 : r_div + DIV_W'(1);
            r_phase <= w_phase_next;
            r_turbo <= w_turbo_next;
        end
    end
`else
    logic w_turbo_div_unused;
    assign w_turbo_div_unused = (TURBO_DIV > 0);
    assign w_turbo_or         = '0;
`endif

    // Outputs are registered from next-state values so a key shows one cycle after its last byte
    always_ff @(posedge clock_25) begin
        if (!reset_n) begin
            r_held      <= '0;
            r_last_up   <= '0;
            r_last_left <= '0;
            r_joy1      <= '0;
            r_joy2      <= '0;
        end else begin
            r_held      <= w_held_next;
            r_last_up   <= w_last_up_next;
            r_last_left <= w_last_left_next;
            r_joy1      <= resolve_dirs(w_held_next[7:0], w_last_up_next[0],
                                        w_last_left_next[0]) | w_turbo_or;
            r_joy2      <= resolve_dirs(w_held_next[15:8], w_last_up_next[1],
                                        w_last_left_next[1]);
        end
    end

    assign joy1 = r_joy1;
    assign joy2 = r_joy2;

endmodule
